// File: rtl/inta_cycle_initiator_pkg.sv
// Shared types and constants for the INTA cycle initiator.
//  state_t       : top-level sequencer states
//  CALL_OPCODE   : first byte the PIC returns in MCS-80 mode
//  PULSES_*      : number of INTA# pulses per acknowledge sequence
package inta_cycle_initiator_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK_LOW = 2'd1,
        ACK_GAP = 2'd2,
        RESULT  = 2'd3
    } state_t;

    localparam logic [7:0] CALL_OPCODE  = 8'hCD;
    localparam logic [1:0] PULSES_8086  = 2'd2;
    localparam logic [1:0] PULSES_MCS80 = 2'd3;
endpackage

// File: rtl/inta_cycle_initiator_if.sv
// Signal bundle between the PIC / CPU core and the INTA cycle initiator.
//  master : the initiator (drives INTA#, busy and the result handshake)
//  slave  : the environment (PIC INT line, data bus, CPU flags, core ready)
interface inta_cycle_initiator_if;
    logic        interrupt;
    logic        interrupt_enable;
    logic        u8086_or_mcs80_config;
    logic [7:0]  data_bus_in;
    logic        interrupt_acknowledge_n;
    logic        busy;
    logic        vector_valid;
    logic        vector_ready;
    logic [7:0]  vector;
    logic [15:0] call_address;
    logic        opcode_error;

    modport master (
        input  interrupt, interrupt_enable, u8086_or_mcs80_config, data_bus_in, vector_ready,
        output interrupt_acknowledge_n, busy, vector_valid, vector, call_address, opcode_error
    );

    modport slave (
        output interrupt, interrupt_enable, u8086_or_mcs80_config, data_bus_in, vector_ready,
        input  interrupt_acknowledge_n, busy, vector_valid, vector, call_address, opcode_error
    );
endinterface

// File: rtl/inta_pulse_timer.sv
// Phase counter for INTA# low / gap intervals.
//  clock, reset : system clock, synchronous active-high reset
//  clear        : restart the count (asserted on every state change)
//  run          : count while in a pulse or gap phase
//  gap_sel      : 1 = time a gap interval, 0 = time a low interval
//  last_cycle   : current clock is the final clock of the selected interval
module inta_pulse_timer #(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic gap_sel,
    output logic last_cycle
);
    localparam int MAX_CYCLES = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES
                                                                      : INTA_GAP_CYCLES;
    localparam int W = $clog2(MAX_CYCLES + 1);
    localparam logic [W-1:0] LOW_LAST = W'(INTA_LOW_CYCLES - 1);
    localparam logic [W-1:0] GAP_LAST = W'(INTA_GAP_CYCLES - 1);

    logic [W-1:0] count;

    assign last_cycle = (count == (gap_sel ? GAP_LAST : LOW_LAST));

    // Saturates at the terminal value so it never wraps.
    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (run && !last_cycle)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/inta_cycle_initiator.sv
// CPU-side initiator of the 8259A interrupt-acknowledge protocol.
//  clock, reset : system clock, synchronous active-high reset
//  bus          : PIC/core signals (INT, IF, mode, data bus in; INTA#, busy,
//                 vector/call_address/opcode_error with valid/ready handshake out)
// Issues 2 (8086) or 3 (MCS-80) INTA# pulses, captures the PIC byte on the
// last low clock of each pulse and presents the result until accepted.
module inta_cycle_initiator
    import inta_cycle_initiator_pkg::*;
#(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    inta_cycle_initiator_if.master bus
);
    state_t     state, next_state;
    logic [1:0] pulses_total, pulse_idx;
    logic [7:0] byte0, byte1, byte2;
    logic [7:0] byte0_n, byte1_n, byte2_n;
    logic       last_cycle, start, pulse_done, final_pulse, mode_8086;

    assign start       = bus.interrupt & bus.interrupt_enable;
    assign pulse_done  = (state == ACK_LOW) && last_cycle;
    assign final_pulse = (pulse_idx == pulses_total - 2'd1);
    assign mode_8086   = (pulses_total == PULSES_8086);

    inta_pulse_timer #(
        .INTA_LOW_CYCLES(INTA_LOW_CYCLES),
        .INTA_GAP_CYCLES(INTA_GAP_CYCLES)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .clear     (next_state != state),
        .run       ((state == ACK_LOW) || (state == ACK_GAP)),
        .gap_sel   (state == ACK_GAP),
        .last_cycle(last_cycle)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACK_LOW;
            ACK_LOW: if (last_cycle) next_state = final_pulse ? RESULT : ACK_GAP;
            ACK_GAP: if (last_cycle) next_state = ACK_LOW;
            RESULT:  if (bus.vector_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Byte values including the capture happening this clock, so the result
    // registers can load in the same edge that enters RESULT.
    always_comb begin
        byte0_n = byte0;
        byte1_n = byte1;
        byte2_n = byte2;
        if (pulse_done) begin
            case (pulse_idx)
                2'd0:    byte0_n = bus.data_bus_in;
                2'd1:    byte1_n = bus.data_bus_in;
                default: byte2_n = bus.data_bus_in;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            pulses_total            <= PULSES_8086;
            pulse_idx               <= '0;
            byte0                   <= '0;
            byte1                   <= '0;
            byte2                   <= '0;
            bus.interrupt_acknowledge_n <= 1'b1;
            bus.busy                <= 1'b0;
            bus.vector_valid        <= 1'b0;
            bus.vector              <= '0;
            bus.call_address        <= '0;
            bus.opcode_error        <= 1'b0;
        end else begin
            state <= next_state;
            byte0 <= byte0_n;
            byte1 <= byte1_n;
            byte2 <= byte2_n;

            // Mode is frozen at sequence start; later config changes are ignored.
            if (state == IDLE && start) begin
                pulses_total <= bus.u8086_or_mcs80_config ? PULSES_8086 : PULSES_MCS80;
                pulse_idx    <= '0;
            end else if (pulse_done && !final_pulse) begin
                pulse_idx <= pulse_idx + 2'd1;
            end

            if (pulse_done && final_pulse) begin
                bus.vector <= byte1_n;
                if (mode_8086) begin
                    bus.call_address <= {8'h00, byte1_n};
                    bus.opcode_error <= 1'b0;
                end else begin
                    bus.call_address <= {byte2_n, byte1_n};
                    bus.opcode_error <= (byte0_n != CALL_OPCODE);
                end
            end

            // Outputs registered from next_state so they align with the state register.
            bus.interrupt_acknowledge_n <= (next_state != ACK_LOW);
            bus.busy                    <= (next_state != IDLE);
            bus.vector_valid            <= (next_state == RESULT);
        end
    end
endmodule

// File: tb/tb_inta_cycle_initiator.sv
// Self-checking bench for inta_cycle_initiator: directed sequences with
// hand-computed expectations plus a cycle-position reference model.
module tb_inta_cycle_initiator;
    localparam int LOW = 2;
    localparam int GAP = 2;
    localparam int PER = LOW + GAP;

    logic clock;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    inta_cycle_initiator_if bus();

    inta_cycle_initiator #(
        .INTA_LOW_CYCLES(LOW),
        .INTA_GAP_CYCLES(GAP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // PIC data bus: byte per pulse, pulse count derived from observed INTA# pulses.
    logic [7:0] pdata [4];
    int   pcnt = 0;
    logic prev_inta = 1'b1;
    always @(negedge clock) begin
        if (!bus.busy) pcnt = 0;
        else if (!prev_inta && bus.interrupt_acknowledge_n) pcnt++;
        prev_inta = bus.interrupt_acknowledge_n;
        bus.data_bus_in = bus.interrupt_acknowledge_n ? 8'hFF : pdata[pcnt];
    end

    // Reference model: tracks position within the active window and derives
    // INTA# / capture points from pulse arithmetic.
    int         m_phase = 0;   // 0 idle, 1 pulsing, 2 result
    int         m_off = 0, m_len = 0, m_n = 0;
    logic       m_8086 = 1'b1;
    logic [7:0] m_b [3];
    logic       m_known = 1'b1;
    logic [7:0] m_vec = 8'h00;
    logic [15:0] m_call = 16'h0000;
    logic       m_err = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_phase = 0; m_known = 1'b1; m_vec = 8'h00; m_call = 16'h0000; m_err = 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.interrupt && bus.interrupt_enable) begin
                    m_phase = 1;
                    m_8086  = bus.u8086_or_mcs80_config;
                    m_n     = m_8086 ? 2 : 3;
                    m_len   = m_n * LOW + (m_n - 1) * GAP;
                    m_off   = 0;
                    m_known = 1'b0;
                end
                1: begin
                    if (m_off % PER == LOW - 1) m_b[m_off / PER] = bus.data_bus_in;
                    m_off++;
                    if (m_off == m_len) begin
                        m_phase = 2;
                        m_known = 1'b1;
                        m_vec   = m_b[1];
                        m_call  = m_8086 ? {8'h00, m_b[1]} : {m_b[2], m_b[1]};
                        m_err   = !m_8086 && (m_b[0] != 8'hCD);
                    end
                end
                default: if (bus.vector_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clock) begin
        chk("m_inta", bus.interrupt_acknowledge_n,
            !(m_phase == 1 && (m_off % PER) < LOW));
        chk("m_busy", bus.busy, m_phase != 0);
        chk("m_valid", bus.vector_valid, m_phase == 2);
        if (m_known) begin
            chk("m_vector", bus.vector, m_vec);
            chk("m_call", bus.call_address, m_call);
            chk("m_err", bus.opcode_error, m_err);
        end
    end

    task automatic observe(input int n, input int drop_at,
                           output logic [15:0] ih, output logic [15:0] vh);
        ih = '0; vh = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            ih[i] = bus.interrupt_acknowledge_n;
            vh[i] = bus.vector_valid;
            if (i == drop_at) begin
                bus.interrupt = 1'b0;
                bus.interrupt_enable = 1'b0;
                bus.u8086_or_mcs80_config = ~bus.u8086_or_mcs80_config;
            end
        end
    endtask

    task automatic ack();
        bus.vector_ready = 1'b1;
        @(negedge clock);
        bus.vector_ready = 1'b0;
        chk("ack_valid_low", bus.vector_valid, 1'b0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !bus.vector_valid; i++) @(negedge clock);
        chk("wait_valid", bus.vector_valid, 1'b1);
    endtask

    logic [15:0] ih, vh;

    initial begin
        reset = 1'b1;
        bus.interrupt = 1'b0; bus.interrupt_enable = 1'b0;
        bus.u8086_or_mcs80_config = 1'b1; bus.vector_ready = 1'b0;
        pdata = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        repeat (2) @(negedge clock);
        chk("rst_inta", bus.interrupt_acknowledge_n, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_valid", bus.vector_valid, 1'b0);
        chk("rst_vector", bus.vector, 8'h00);
        chk("rst_call", bus.call_address, 16'h0000);
        chk("rst_err", bus.opcode_error, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // 8086: two pulses, vector at T+7
        pdata = '{8'h11, 8'h48, 8'hFF, 8'hFF};
        bus.u8086_or_mcs80_config = 1'b1; bus.interrupt = 1'b1; bus.interrupt_enable = 1'b1;
        observe(7, 0, ih, vh);
        chk("t1_inta_train", ih, 16'b1001100);
        chk("t1_valid_t7", vh, 16'b1000000);
        chk("t1_vector", bus.vector, 8'h48);
        chk("t1_call", bus.call_address, 16'h0048);
        chk("t1_err", bus.opcode_error, 1'b0);
        ack();

        // MCS-80: three pulses, CALL opcode ok, then bad opcode
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            pdata = '{(k == 0) ? 8'hCD : 8'hC3, 8'h20, 8'h13, 8'hFF};
            bus.u8086_or_mcs80_config = 1'b0; bus.interrupt = 1'b1; bus.interrupt_enable = 1'b1;
            observe(11, 0, ih, vh);
            chk("t2_inta_train", ih, 16'b10011001100);
            chk("t2_valid_t11", vh, 16'b10000000000);
            chk("t2_vector", bus.vector, 8'h20);
            chk("t2_call", bus.call_address, 16'h1320);
            chk("t2_err", bus.opcode_error, (k == 0) ? 1'b0 : 1'b1);
            ack();
        end

        // Interrupt pending with IF clear: no sequence
        @(negedge clock);
        pdata = '{8'h00, 8'h5A, 8'hFF, 8'hFF};
        bus.u8086_or_mcs80_config = 1'b1; bus.interrupt = 1'b1; bus.interrupt_enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("t3_gate_inta", bus.interrupt_acknowledge_n, 1'b1);
            chk("t3_gate_busy", bus.busy, 1'b0);
        end
        bus.interrupt_enable = 1'b1;
        @(negedge clock);
        chk("t3_start_inta", bus.interrupt_acknowledge_n, 1'b0);
        chk("t3_start_busy", bus.busy, 1'b1);
        wait_valid();

        // Core stalls with INT still high: result held, no new pulses
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("t4_hold_valid", bus.vector_valid, 1'b1);
            chk("t4_hold_vector", bus.vector, 8'h5A);
            chk("t4_hold_inta", bus.interrupt_acknowledge_n, 1'b1);
        end
        bus.vector_ready = 1'b1;
        @(negedge clock);
        bus.vector_ready = 1'b0;
        chk("t4_idle_busy", bus.busy, 1'b0);
        chk("t4_idle_valid", bus.vector_valid, 1'b0);
        @(negedge clock);
        chk("t4_rearm_inta", bus.interrupt_acknowledge_n, 1'b0);
        bus.interrupt = 1'b0; bus.interrupt_enable = 1'b0;
        wait_valid();
        ack();

        // Inputs dropped during first gap: sequence still completes
        @(negedge clock);
        pdata = '{8'h01, 8'h77, 8'hFF, 8'hFF};
        bus.u8086_or_mcs80_config = 1'b1; bus.interrupt = 1'b1; bus.interrupt_enable = 1'b1;
        observe(7, 2, ih, vh);
        chk("t5_inta_train", ih, 16'b1001100);
        chk("t5_valid_t7", vh, 16'b1000000);
        chk("t5_call", bus.call_address, 16'h0077);
        ack();

        // Reset during second low pulse
        @(negedge clock);
        pdata = '{8'hAA, 8'hBB, 8'hFF, 8'hFF};
        bus.u8086_or_mcs80_config = 1'b1; bus.interrupt = 1'b1; bus.interrupt_enable = 1'b1;
        repeat (5) @(negedge clock);
        chk("t6_second_low", bus.interrupt_acknowledge_n, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk("t6_inta", bus.interrupt_acknowledge_n, 1'b1);
        chk("t6_busy", bus.busy, 1'b0);
        chk("t6_valid", bus.vector_valid, 1'b0);
        chk("t6_vector", bus.vector, 8'h00);
        chk("t6_call", bus.call_address, 16'h0000);
        chk("t6_err", bus.opcode_error, 1'b0);
        reset = 1'b0; bus.interrupt = 1'b0; bus.interrupt_enable = 1'b0;
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
